// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder for one DVI/HDMI colour lane.
// Ports: clk, rst (sync, active-high), VD[7:0], CD[1:0], VDE -> TMDS[9:0] (registered, bit 0 first).
module tmds_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] VD,
  input  logic [1:0] CD,
  input  logic       VDE,
  output logic [9:0] TMDS
);

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      s = s + {3'b000, v[i]};
    return s;
  endfunction

  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic signed [4:0] bal;
  logic [9:0]        sym;
  logic [9:0]        tok;
  logic [8:0]        q_m;
  logic [3:0]        n1_vd;
  logic [3:0]        n1_q;
  logic              use_xnor;
  logic              case_a;
  logic              case_b;

  // Stage 1: transition-minimising chain.
  always_comb begin
    n1_vd    = popcnt8(VD);
    use_xnor = (n1_vd > 4'd4) || ((n1_vd == 4'd4) && !VD[0]);
    q_m      = '0;
    q_m[0]   = VD[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ VD[i]) : (q_m[i-1] ^ VD[i]);
    q_m[8]   = ~use_xnor;
  end

  // bal = n1 - n0 = 2*n1 - 8; 5-bit modular maths keeps it exact.
  assign n1_q = popcnt8(q_m[7:0]);
  assign bal  = $signed({n1_q, 1'b0}) - 5'sd8;

  always_comb begin
    case_a   = (cnt == 5'sd0) || (bal == 5'sd0);
    case_b   = (!cnt[4] && !bal[4]) || (cnt[4] && bal[4]);
    sym      = '0;
    cnt_next = cnt;
    if (case_a) begin
      sym      = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next = q_m[8] ? cnt + bal : cnt - bal;
    end else if (case_b) begin
      sym      = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - bal;
    end else begin
      sym      = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt + bal - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_comb begin
    tok = TOK0;
    unique case (CD)
      2'b00: tok = TOK0;
      2'b01: tok = TOK1;
      2'b10: tok = TOK2;
      2'b11: tok = TOK3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      TMDS <= TOK0;
      cnt  <= 5'sd0;
    end else if (!VDE) begin
      TMDS <= tok;
      cnt  <= 5'sd0;
    end else begin
      TMDS <= sym;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed symbols plus a
// decoded random stream with running-disparity bound.
module tb_tmds_encoder;

  typedef struct packed {
    logic       ctl;
    logic       exact;
    logic [9:0] sym;
    logic [7:0] vd;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic [9:0] TMDS;

  item_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    disp     = 0;
  logic [9:0] tok [4];

  tmds_encoder dut (
    .clk (clk),
    .rst (rst),
    .VD  (VD),
    .CD  (CD),
    .VDE (VDE),
    .TMDS(TMDS)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w;
    logic [7:0] d;
    w = s[9] ? ~s[7:0] : s[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return d;
  endfunction

  task automatic drive(input logic r, input logic vde,
                       input logic [7:0] vd, input logic [1:0] cd,
                       input logic ex, input logic [9:0] e);
    item_t it;
    rst = r;
    VDE = vde;
    VD  = vd;
    CD  = cd;
    it.ctl   = r | ~vde;
    it.exact = ex;
    it.sym   = e;
    it.vd    = vd;
    q.push_back(it);
    @(negedge clk);
  endtask

  task automatic px(input logic [7:0] vd, input logic [9:0] e);
    drive(1'b0, 1'b1, vd, 2'b00, 1'b1, e);
  endtask

  task automatic blank(input logic [1:0] cd, input logic [9:0] e);
    drive(1'b0, 1'b0, 8'h00, cd, 1'b1, e);
  endtask

  // Monitor: one symbol per edge, compared after the edge.
  always @(posedge clk) begin
    item_t it;
    int    d;
    #1;
    if (q.size() != 0) begin
      it = q.pop_front();
      n_checks++;
      if (it.exact) begin
        if (TMDS !== it.sym) begin
          n_fail++;
          $display("FAIL sym t=%0t got=%h exp=%h", $time, TMDS, it.sym);
        end
      end else if (decode(TMDS) !== it.vd) begin
        n_fail++;
        $display("FAIL decode t=%0t sym=%h got=%h exp=%h",
                 $time, TMDS, decode(TMDS), it.vd);
      end
      if (it.ctl) begin
        disp = 0;
      end else begin
        d = $countones(TMDS);
        disp = disp + 2 * d - 10;
        n_checks++;
        if (disp > 8 || disp < -8) begin
          n_fail++;
          $display("FAIL disparity t=%0t got=%0d exp=|d|<=8", $time, disp);
        end
      end
    end
  end

  initial begin
    tok[0] = 10'h354;
    tok[1] = 10'h0AB;
    tok[2] = 10'h154;
    tok[3] = 10'h2AB;

    // reset and control tokens
    drive(1'b1, 1'b1, 8'hA5, 2'b11, 1'b1, 10'h354);
    blank(2'b00, 10'h354);
    blank(2'b01, 10'h0AB);
    blank(2'b10, 10'h154);
    blank(2'b11, 10'h2AB);

    // N1==4, VD[0]=0 -> XNOR; cnt 0,-4,-2,0
    blank(2'b00, 10'h354);
    px(8'hF0, 10'h205);
    px(8'hF0, 10'h0FA);
    px(8'hF0, 10'h0FA);
    px(8'hF0, 10'h205);

    // zeros: -8 then +2; then 0xFF with cnt>0 -> case B
    blank(2'b00, 10'h354);
    px(8'h00, 10'h100);
    px(8'h00, 10'h3FF);
    px(8'hFF, 10'h200);

    // 0xFF from 0 -> -8; 0x01 back to 0; 0x10 balanced
    blank(2'b00, 10'h354);
    px(8'hFF, 10'h200);
    px(8'h01, 10'h1FF);
    px(8'h10, 10'h1F0);

    // mid-stream reset clears disparity
    px(8'hFF, 10'h200);
    drive(1'b1, 1'b1, 8'h00, 2'b01, 1'b1, 10'h354);
    px(8'hFF, 10'h200);

    // VDE toggling every cycle
    for (int i = 0; i < 4; i++) begin
      px(8'h55, 10'h133);
      blank(2'b10, 10'h154);
    end
    for (int i = 0; i < 3; i++) begin
      px(8'h00, 10'h100);
      blank(2'b10, 10'h154);
    end

    // random stream with periodic blanking
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      if (i % 800 == 0) begin
        for (int k = 0; k < 4; k++) begin
          c = 2'($urandom_range(0, 3));
          drive(1'b0, 1'b0, 8'h00, c, 1'b1, tok[c]);
        end
      end
      drive(1'b0, 1'b1, 8'($urandom), 2'($urandom), 1'b0, 10'h000);
    end

    blank(2'b00, 10'h354);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d exp=0 pending", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
